port_data: RTL and testbench
============================

Name: port_data

Overview:
- Data-direction counterpart of the TRIS register block. The TRIS block drives pin direction; this block moves data across the pins.
- Outbound path: output latches PORTA/PORTB/PORTC, written by file-register writes from the core.
- Inbound path: 2-flop synchronizers on the external pins, a registered read path back to the core's file-register read mux, and a PORTB change-detect flag used for wake-up.
- Sits between the core's file-register bus, the TRIS block outputs and the chip pads.

Parameters:
- IO_A_WIDTH, 4, PORTA pin count (shared define)
- IO_B_WIDTH, 8, PORTB pin count (shared define)
- IO_C_WIDTH, 8, PORTC pin count (shared define)
- DATA_WIDTH, 8, core data width (shared define)
- ADDR_WIDTH, 5, file-register address width

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wrEn  in  1  file-register write strobe
- rdEn  in  1  file-register read strobe
- addr  in  ADDR_WIDTH  file-register address; 5=PORTA, 6=PORTB, 7=PORTC
- wrData  in  DATA_WIDTH  write data
- trisAReg  in  IO_A_WIDTH  direction, 1=input, from TRIS block
- trisBReg  in  IO_B_WIDTH  direction, from TRIS block
- trisCReg  in  IO_C_WIDTH  direction, from TRIS block
- pinA  in  IO_A_WIDTH  raw asynchronous pad input
- pinB  in  IO_B_WIDTH  raw asynchronous pad input
- pinC  in  IO_C_WIDTH  raw asynchronous pad input
- portAOut  out  IO_A_WIDTH  output latch to pad driver
- portBOut  out  IO_B_WIDTH  output latch to pad driver
- portCOut  out  IO_C_WIDTH  output latch to pad driver
- rdData  out  DATA_WIDTH  registered read data
- rdValid  out  1  rdData valid; high exactly one cycle after an accepted read
- rbChange  out  1  sticky PORTB input-pin change flag

Behaviour:
- Reset (rst_n low, asynchronous, any cycle, including mid-read):
  - all latches, synchronizer stages, rdData, rdValid, rbChange and the PORTB snapshot go to 0.
  - A read in flight is discarded; rdValid stays 0.
- Synchronizers: each pin bit passes through 2 flops. syncX is pinX delayed 2 cycles.
- Write:
  - wrEn with addr 5/6/7 loads the matching latch at the next edge.
  - PORTA takes wrData[IO_A_WIDTH-1:0]; upper bits are ignored.
  - Other addresses are ignored.
  - Latches update regardless of TRIS setting.
- Read:
  - rdEn with addr 5/6/7 is an accepted read.
  - Next cycle: rdData = syncX zero-extended to DATA_WIDTH, rdValid=1.
  - Read always returns the synchronized pin, never the latch, so read-modify-write semantics follow pin state.
  - rdEn with any other address: rdValid=0 and rdData holds its previous value.
  - Back-to-back reads every cycle are legal. rdValid stays high and each result lags its request by 1.
- Simultaneous wrEn and rdEn to the same port: the read returns the pre-write synchronized pin value. The write takes effect in the latch the same edge.
- rbChange:
  - rbSnap holds the syncB value captured at the last PORTB read.
  - Each cycle, for bits with trisBReg=1: if syncB differs from rbSnap, rbChange is set.
  - A PORTB read loads rbSnap with syncB and clears rbChange.
  - If a mismatch is evaluated against the new snapshot in the same cycle as the read, set wins.
  - Bits with trisBReg=0 never set the flag.
  - A TRIS change alone never sets the flag, until the pin itself differs from the snapshot.
- No combinational path from any input to any output. All outputs are registered.

Decomposition:
- Shared define file holds IO_A/B/C_WIDTH, DATA_WIDTH, ADDR_WIDTH, and the PORTA/PORTB/PORTC address constants (5/6/7).
- One sub-module: sync2, a parameterized-width 2-flop synchronizer with async active-low reset. It is instantiated three times.

Test Plan:
- Reset: assert rst_n low mid-simulation, asynchronously → all outputs 0 before the next clk edge; rdValid 0.
- Write then output: wrEn addr=6 wrData=8'hA5 → portBOut=8'hA5 next cycle; wrEn addr=5 wrData=8'hFF → portAOut=4'hF.
- Read latency: pinC=8'h3C held; rdEn addr=7 issued 3+ cycles later → rdData=8'h3C and rdValid=1 exactly 1 cycle later. Pin change then immediate read → old value, since 2-cycle synchronizer lag.
- Simultaneous: pinB=8'h00, latch 8'h00; wrEn+rdEn addr=6 wrData=8'hFF same cycle → rdData=8'h00, portBOut=8'hFF.
- Change detect:
  - trisBReg=8'hF0, read PORTB to snapshot.
  - Toggle pinB[0] → rbChange stays 0.
  - Toggle pinB[7] → rbChange=1 within 3 cycles.
  - Read PORTB → rbChange=0.
- Invalid address: rdEn addr=4 → rdValid=0, rdData unchanged; wrEn addr=8 → no latch changes.

Source files
------------

// File: rtl/port_data_pkg.sv
// Shared constants for the port data block: pin counts, core data/address widths and the
// file-register addresses of PORTA/PORTB/PORTC, plus the address decode helper.
package port_data_pkg;

  localparam int unsigned IO_A_WIDTH = 4;
  localparam int unsigned IO_B_WIDTH = 8;
  localparam int unsigned IO_C_WIDTH = 8;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ADDR_WIDTH = 5;

  localparam logic [ADDR_WIDTH-1:0] PORTA_ADDR = 5'd5;
  localparam logic [ADDR_WIDTH-1:0] PORTB_ADDR = 5'd6;
  localparam logic [ADDR_WIDTH-1:0] PORTC_ADDR = 5'd7;

  typedef enum logic [1:0] {
    PortNone,
    PortA,
    PortB,
    PortC
  } portSel_e;

  function automatic portSel_e decodePort(logic [ADDR_WIDTH-1:0] a);
    case (a)
      PORTA_ADDR: return PortA;
      PORTB_ADDR: return PortB;
      PORTC_ADDR: return PortC;
      default:    return PortNone;
    endcase
  endfunction

endpackage

// File: rtl/port_data_if.sv
// File-register bus between the core and the port data block.
//   wrEn/rdEn  : write / read strobes
//   addr       : file-register address
//   wrData     : write data
//   rdData     : registered read data (one cycle after an accepted read)
//   rdValid    : rdData valid
// master = core side, slave = port data block.
interface port_data_if;
  import port_data_pkg::*;

  logic                  wrEn;
  logic                  rdEn;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wrData;
  logic [DATA_WIDTH-1:0] rdData;
  logic                  rdValid;

  modport master (
    output wrEn, rdEn, addr, wrData,
    input  rdData, rdValid
  );

  modport slave (
    input  wrEn, rdEn, addr, wrData,
    output rdData, rdValid
  );

endinterface

// File: rtl/port_data_sync2.sv
// Two-flop synchronizer for asynchronous pad inputs.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both stages
//   d     : raw asynchronous input
//   q     : d delayed by two clk edges
module port_data_sync2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] stage1Q;
  logic [Width-1:0] stage2Q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1Q <= '0;
      stage2Q <= '0;
    end else begin
      stage1Q <= d;
      stage2Q <= stage1Q;
    end
  end

  assign q = stage2Q;

endmodule

// File: rtl/port_data.sv
// Port data block: output latches for PORTA/B/C, synchronized pin read-back and the
// PORTB change-detect (wake-up) flag.
//   clk, rst_n       : core clock, asynchronous active-low reset
//   bus              : file-register bus (slave side)
//   trisXReg         : pin direction from the TRIS block, 1 = input
//   pinX             : raw asynchronous pad inputs
//   portXOut         : output latches to the pad drivers
//   rbChange         : sticky PORTB input change flag, cleared by a PORTB read
module port_data
  import port_data_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  port_data_if.slave            bus,
  input  logic [IO_A_WIDTH-1:0] trisAReg,
  input  logic [IO_B_WIDTH-1:0] trisBReg,
  input  logic [IO_C_WIDTH-1:0] trisCReg,
  input  logic [IO_A_WIDTH-1:0] pinA,
  input  logic [IO_B_WIDTH-1:0] pinB,
  input  logic [IO_C_WIDTH-1:0] pinC,
  output logic [IO_A_WIDTH-1:0] portAOut,
  output logic [IO_B_WIDTH-1:0] portBOut,
  output logic [IO_C_WIDTH-1:0] portCOut,
  output logic                  rbChange
);

  logic [IO_A_WIDTH-1:0] syncA;
  logic [IO_B_WIDTH-1:0] syncB;
  logic [IO_C_WIDTH-1:0] syncC;

  port_data_sync2 #(.Width(IO_A_WIDTH)) u_syncA (.clk(clk), .rst_n(rst_n), .d(pinA), .q(syncA));
  port_data_sync2 #(.Width(IO_B_WIDTH)) u_syncB (.clk(clk), .rst_n(rst_n), .d(pinB), .q(syncB));
  port_data_sync2 #(.Width(IO_C_WIDTH)) u_syncC (.clk(clk), .rst_n(rst_n), .d(pinC), .q(syncC));

  // Direction only matters for PORTB change detect; A/C directions are not needed here.
  logic unusedTris;
  assign unusedTris = ^{trisAReg, trisCReg};

  portSel_e sel;
  assign sel = decodePort(bus.addr);

  logic [IO_A_WIDTH-1:0] portAQ, portAD;
  logic [IO_B_WIDTH-1:0] portBQ, portBD;
  logic [IO_C_WIDTH-1:0] portCQ, portCD;
  logic [DATA_WIDTH-1:0] rdDataQ, rdDataD;
  logic                  rdValidQ, rdValidD;
  logic [IO_B_WIDTH-1:0] rbSnapQ, rbSnapD;
  logic                  rbChangeQ, rbChangeD;
  logic                  readB;
  logic [IO_B_WIDTH-1:0] snapEff;

  // Write path: latches load regardless of TRIS.
  always_comb begin
    portAD = portAQ;
    portBD = portBQ;
    portCD = portCQ;
    if (bus.wrEn) begin
      unique case (sel)
        PortA:   portAD = bus.wrData[IO_A_WIDTH-1:0];
        PortB:   portBD = bus.wrData[IO_B_WIDTH-1:0];
        PortC:   portCD = bus.wrData[IO_C_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Read path: always returns the synchronized pins, zero-extended. A simultaneous write
  // to the same port does not affect the value read.
  always_comb begin
    rdDataD  = rdDataQ;
    rdValidD = 1'b0;
    if (bus.rdEn) begin
      unique case (sel)
        PortA: begin
          rdDataD                 = '0;
          rdDataD[IO_A_WIDTH-1:0] = syncA;
          rdValidD                = 1'b1;
        end
        PortB: begin
          rdDataD                 = '0;
          rdDataD[IO_B_WIDTH-1:0] = syncB;
          rdValidD                = 1'b1;
        end
        PortC: begin
          rdDataD                 = '0;
          rdDataD[IO_C_WIDTH-1:0] = syncC;
          rdValidD                = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Change detect: on a PORTB read the comparison uses the freshly captured snapshot, so a
  // read clears the flag unless a mismatch against that new snapshot exists (set wins).
  always_comb begin
    readB     = bus.rdEn && (sel == PortB);
    snapEff   = readB ? syncB : rbSnapQ;
    rbSnapD   = snapEff;
    rbChangeD = (rbChangeQ && !readB) || (|((syncB ^ snapEff) & trisBReg));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      portAQ    <= '0;
      portBQ    <= '0;
      portCQ    <= '0;
      rdDataQ   <= '0;
      rdValidQ  <= 1'b0;
      rbSnapQ   <= '0;
      rbChangeQ <= 1'b0;
    end else begin
      portAQ    <= portAD;
      portBQ    <= portBD;
      portCQ    <= portCD;
      rdDataQ   <= rdDataD;
      rdValidQ  <= rdValidD;
      rbSnapQ   <= rbSnapD;
      rbChangeQ <= rbChangeD;
    end
  end

  assign portAOut    = portAQ;
  assign portBOut    = portBQ;
  assign portCOut    = portCQ;
  assign bus.rdData  = rdDataQ;
  assign bus.rdValid = rdValidQ;
  assign rbChange    = rbChangeQ;

endmodule

// File: tb/tb_port_data.sv
// Scoreboard bench for port_data: reads push their expected result into a queue at the
// accepting edge; a negedge monitor pops and compares whenever rdValid is (or should be) high.
module tb_port_data;
  import port_data_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic [IO_A_WIDTH-1:0] trisAReg, pinA, portAOut;
  logic [IO_B_WIDTH-1:0] trisBReg, pinB, portBOut;
  logic [IO_C_WIDTH-1:0] trisCReg, pinC, portCOut;
  logic                  rbChange;

  port_data_if bus ();

  port_data dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .trisAReg (trisAReg),
    .trisBReg (trisBReg),
    .trisCReg (trisCReg),
    .pinA     (pinA),
    .pinB     (pinB),
    .pinC     (pinC),
    .portAOut (portAOut),
    .portBOut (portBOut),
    .portCOut (portCOut),
    .rbChange (rbChange)
  );

  int checks = 0;
  int errors = 0;
  logic [DATA_WIDTH-1:0] expQ[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
    bus.wrEn   = 1'b1;
    bus.addr   = a;
    bus.wrData = d;
    @(posedge clk);
    #1 bus.wrEn = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] exp);
    bus.rdEn = 1'b1;
    bus.addr = a;
    @(posedge clk);
    expQ.push_back(exp);
    #1 bus.rdEn = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, " portAOut"}, portAOut, 0);
    check({tag, " portBOut"}, portBOut, 0);
    check({tag, " portCOut"}, portCOut, 0);
    check({tag, " rdData"}, bus.rdData, 0);
    check({tag, " rdValid"}, bus.rdValid, 0);
    check({tag, " rbChange"}, rbChange, 0);
  endtask

  // Monitor: rdValid must be high exactly when a result is pending.
  always @(negedge clk) begin : monitor
    logic [DATA_WIDTH-1:0] exp;
    if (bus.rdValid || expQ.size() != 0) begin
      checks++;
      if (!bus.rdValid) begin
        errors++;
        $display("FAIL rdValid missing: got 0, required 1");
        exp = expQ.pop_front();
      end else if (expQ.size() == 0) begin
        errors++;
        $display("FAIL rdValid unexpected: got 1, required 0 (rdData %0h)", bus.rdData);
      end else begin
        exp = expQ.pop_front();
        if (bus.rdData !== exp) begin
          errors++;
          $display("FAIL rdData: got %0h, required %0h", bus.rdData, exp);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    bus.wrEn   = 1'b0;
    bus.rdEn   = 1'b0;
    bus.addr   = '0;
    bus.wrData = '0;
    trisAReg   = '0;
    trisBReg   = '0;
    trisCReg   = '0;
    pinA       = '0;
    pinB       = '0;
    pinC       = '0;

    cycles(2);
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);

    // Writes
    wr(PORTB_ADDR, 8'hA5);
    @(negedge clk) check("portBOut after write", portBOut, 8'hA5);
    wr(PORTA_ADDR, 8'hFF);
    @(negedge clk) check("portAOut after write", portAOut, 4'hF);
    wr(PORTC_ADDR, 8'h5A);
    @(negedge clk) check("portCOut after write", portCOut, 8'h5A);
    check("portBOut unchanged", portBOut, 8'hA5);

    // Read latency and synchronizer lag
    cycles(1);
    pinC = 8'h3C;
    cycles(3);
    rd(PORTC_ADDR, 8'h3C);
    pinC = 8'hC3;
    rd(PORTC_ADDR, 8'h3C);
    cycles(3);
    rd(PORTC_ADDR, 8'hC3);
    pinA = 4'h9;
    cycles(3);
    rd(PORTA_ADDR, 8'h09);

    // Back-to-back reads
    pinB = 8'h81;
    cycles(3);
    rd(PORTB_ADDR, 8'h81);
    rd(PORTC_ADDR, 8'hC3);
    rd(PORTA_ADDR, 8'h09);
    cycles(2);
    check("rbChange with tris 0", rbChange, 0);

    // Simultaneous write and read of PORTB
    pinB = 8'h00;
    wr(PORTB_ADDR, 8'h00);
    cycles(3);
    bus.wrEn   = 1'b1;
    bus.rdEn   = 1'b1;
    bus.addr   = PORTB_ADDR;
    bus.wrData = 8'hFF;
    @(posedge clk);
    expQ.push_back(8'h00);
    #1;
    bus.wrEn = 1'b0;
    bus.rdEn = 1'b0;
    @(negedge clk) check("portBOut after wr+rd", portBOut, 8'hFF);

    // Change detect
    trisBReg = 8'hF0;
    rd(PORTB_ADDR, 8'h00);
    @(negedge clk) check("rbChange after snapshot", rbChange, 0);
    @(posedge clk);
    #1 pinB = 8'h01;
    cycles(4);
    @(negedge clk) check("rbChange output bit toggle", rbChange, 0);
    @(posedge clk);
    #1 pinB = 8'h81;
    repeat (3) @(posedge clk);
    @(negedge clk) check("rbChange input bit toggle", rbChange, 1);
    rd(PORTB_ADDR, 8'h81);
    @(negedge clk) check("rbChange cleared by read", rbChange, 0);
    trisBReg = 8'hFF;
    cycles(2);
    @(negedge clk) check("rbChange tris change only", rbChange, 0);

    // Invalid addresses
    @(posedge clk);
    #1;
    bus.rdEn = 1'b1;
    bus.addr = 5'd4;
    @(posedge clk);
    #1 bus.rdEn = 1'b0;
    @(negedge clk);
    check("rdValid bad addr", bus.rdValid, 0);
    check("rdData held bad addr", bus.rdData, 8'h81);
    wr(5'd8, 8'h00);
    @(negedge clk);
    check("portAOut bad wr addr", portAOut, 4'hF);
    check("portBOut bad wr addr", portBOut, 8'hFF);
    check("portCOut bad wr addr", portCOut, 8'h5A);

    // Asynchronous reset mid-read
    @(posedge clk);
    #1;
    bus.rdEn = 1'b1;
    bus.addr = PORTC_ADDR;
    #2 rst_n = 1'b0;
    #1 checkAllZero("async reset");
    @(posedge clk);
    #1 bus.rdEn = 1'b0;
    @(negedge clk) check("rdValid read discarded", bus.rdValid, 0);
    rst_n = 1'b1;
    cycles(1);
    @(negedge clk) checkAllZero("after reset");

    cycles(3);
    check("scoreboard drained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
